// File: rtl/corr_readout_seq.sv
// corr_readout_seq: host-facing readout sequencer for the multi-tau correlator
// result RAM banks. Decodes a host address into a per-bank read, waits out the
// RAM read latency, and holds the word under a valid/ready handshake. Illegal
// addresses return FILL with rd_err set.
// Optional feature macro: CORR_RDSEQ_BURST_EN streams a whole bank as a burst.
module corr_readout_seq #(
  parameter int          NUM_BANKS = 5,
  parameter int          DATA_W    = 32,
  parameter int          BASE_AW   = 5,
  parameter int          RAM_LAT   = 1,
  parameter logic [31:0] FILL      = 32'hAAAAAAAA,
  localparam int         AWM       = BASE_AW + NUM_BANKS - 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_req,
  input  logic [15:0]                 rd_addr,
  output logic                        rd_busy,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_err,
  output logic                        rd_last,
  input  logic                        burst_req,
  output logic [NUM_BANKS-1:0]        ram_en,
  output logic [AWM-1:0]              ram_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] ram_data
);

  localparam int LCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [DATA_W-1:0] FILL_W = DATA_W'(FILL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3
`ifdef CORR_RDSEQ_BURST_EN
    ,
    BNEXT = 3'd4
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [AWM-1:0]      addr_reg, addr_next;
  logic [3:0]          bank_reg, bank_next;
  logic [LCW-1:0]      lat_reg, lat_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                err_reg, err_next;

  // Address decode of the live host address (only meaningful in IDLE)
  int                  sel_int;
  logic                sel_ok;
  logic                off_ok;
  logic [3:0]          sel_idx;
  logic [DATA_W-1:0]   sel_data;

`ifdef CORR_RDSEQ_BURST_EN
  logic                burst_reg, burst_next;
  logic                last_reg, last_next;
  logic [31:0]         mask_full;
  logic                last_word;
`else
  logic                unused_burst_req;
  assign unused_burst_req = burst_req;
`endif

  // Decode bank select and check the offset fits inside the selected bank
  always_comb begin
    sel_int = int'(rd_addr[15:12]);
    sel_ok  = (sel_int >= 1) && (sel_int <= NUM_BANKS);
    off_ok  = ((32'(rd_addr[11:0]) >> (BASE_AW + sel_int - 1)) == 32'd0);
    sel_idx = 4'(sel_int - 1);
  end

  // Pick the data slice of the bank being read
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_reg == 4'(i)) sel_data = ram_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef CORR_RDSEQ_BURST_EN
  // A burst ends when the offset reaches the top word of the bank
  always_comb begin
    mask_full = (32'd1 << (BASE_AW + int'(bank_reg))) - 32'd1;
    last_word = (addr_reg == mask_full[AWM-1:0]);
  end
`endif

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    bank_next  = bank_reg;
    lat_next   = lat_reg;
    data_next  = data_reg;
    err_next   = err_reg;
`ifdef CORR_RDSEQ_BURST_EN
    burst_next = burst_reg;
    last_next  = last_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef CORR_RDSEQ_BURST_EN
        if (burst_req) begin
          if (sel_ok) begin
            burst_next = 1'b1;
            bank_next  = sel_idx;
            addr_next  = '0;
            state_next = ISSUE;
          end else begin
            burst_next = 1'b0;
            data_next  = FILL_W;
            err_next   = 1'b1;
            last_next  = 1'b1;
            state_next = OUT;
          end
        end else
`endif
        if (rd_req) begin
`ifdef CORR_RDSEQ_BURST_EN
          burst_next = 1'b0;
          last_next  = 1'b1;
`endif
          if (sel_ok && off_ok) begin
            bank_next  = sel_idx;
            addr_next  = rd_addr[AWM-1:0];
            state_next = ISSUE;
          end else begin
            data_next  = FILL_W;
            err_next   = 1'b1;
            state_next = OUT;
          end
        end
      end
      ISSUE: begin
        lat_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (lat_reg == LCW'(RAM_LAT - 1)) begin
          data_next  = sel_data;
          err_next   = 1'b0;
`ifdef CORR_RDSEQ_BURST_EN
          last_next  = !burst_reg || last_word;
`endif
          state_next = OUT;
        end else begin
          lat_next = lat_reg + LCW'(1);
        end
      end
      OUT: begin
        if (rd_ready) begin
`ifdef CORR_RDSEQ_BURST_EN
          if (burst_reg && !last_reg) state_next = BNEXT;
          else                        state_next = IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef CORR_RDSEQ_BURST_EN
      BNEXT: begin
        addr_next  = addr_reg + AWM'(1);
        state_next = ISSUE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      bank_reg  <= '0;
      lat_reg   <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
`ifdef CORR_RDSEQ_BURST_EN
      burst_reg <= 1'b0;
      last_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      bank_reg  <= bank_next;
      lat_reg   <= lat_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
`ifdef CORR_RDSEQ_BURST_EN
      burst_reg <= burst_next;
      last_reg  <= last_next;
`endif
    end
  end

  // One-hot bank enable, only during the single ISSUE cycle
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_en
    assign ram_en[gi] = (state_reg == ISSUE) && (bank_reg == 4'(gi));
  end

  assign rd_busy  = (state_reg != IDLE);
  assign rd_valid = (state_reg == OUT);
  assign rd_data  = data_reg;
  assign rd_err   = err_reg;
  assign ram_addr = addr_reg;
`ifdef CORR_RDSEQ_BURST_EN
  assign rd_last  = rd_valid && last_reg;
`else
  assign rd_last  = rd_valid;
`endif

endmodule

// File: tb/tb_corr_readout_seq.sv
// Testbench for corr_readout_seq: random reads against a behavioural model of
// the address map and handshake timing, plus the directed cases.
module tb_corr_readout_seq;

  localparam int          NB    = 5;
  localparam int          DW    = 32;
  localparam int          BAW   = 5;
  localparam int          LAT   = 1;
  localparam int          AWM   = BAW + NB - 1;
  localparam logic [31:0] FILLV = 32'hAAAAAAAA;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_req = 1'b0;
  logic [15:0]       rd_addr = '0;
  logic              rd_ready = 1'b0;
  logic              burst_req = 1'b0;
  logic              rd_busy, rd_valid, rd_err, rd_last;
  logic [DW-1:0]     rd_data;
  logic [NB-1:0]     ram_en;
  logic [AWM-1:0]    ram_addr;
  logic [NB*DW-1:0]  ram_data;

  logic [DW-1:0]     mem [NB][512];
  logic [DW-1:0]     q [NB];
  int                n_checks = 0;
  int                n_errors = 0;
  int                en_pulses = 0;

  always #5 clk = ~clk;

  corr_readout_seq #(
    .NUM_BANKS(NB), .DATA_W(DW), .BASE_AW(BAW), .RAM_LAT(LAT), .FILL(FILLV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_err(rd_err), .rd_last(rd_last),
    .burst_req(burst_req), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_data(ram_data)
  );

  // Bank RAMs with one cycle of read latency; count every enable seen
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (ram_en[b]) q[b] <= mem[b][int'(ram_addr) & ((1 << (BAW + b)) - 1)];
    if (ram_en != '0) en_pulses <= en_pulses + $countones(ram_en);
  end

  always_comb begin
    for (int b = 0; b < NB; b++) ram_data[b*DW +: DW] = q[b];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {err, data} for a host address, straight from the address map
  function automatic logic [32:0] model(input logic [15:0] a);
    int s;
    int off;
    s   = int'(a[15:12]);
    off = int'(a[11:0]);
    if (s >= 1 && s <= NB && off < (1 << (BAW + s - 1)))
      return {1'b0, mem[s-1][off]};
    return {1'b1, FILLV};
  endfunction

  task automatic do_read(input logic [15:0] a, input int stall);
    logic [32:0]   e;
    logic [DW-1:0] hold;
    int            n;
    int            p0;
    bit            legal;
    e     = model(a);
    legal = !e[32];
    chk("idle_busy", 64'(rd_busy), 64'd0);
    p0 = en_pulses;
`ifndef CORR_RDSEQ_BURST_EN
    burst_req = 1'($urandom_range(0, 1));
`endif
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req    = 1'b0;
    burst_req = 1'b0;
    chk("busy_acc", 64'(rd_busy), 64'd1);
    if (legal) begin
      chk("ram_en", 64'(ram_en), 64'(NB'(1) << (int'(a[15:12]) - 1)));
      chk("ram_addr", 64'(ram_addr), 64'(a[11:0]));
    end else begin
      chk("ram_en_ill", 64'(ram_en), 64'd0);
    end
    n = 0;
    while (!rd_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), legal ? 64'(1 + LAT) : 64'd0);
    chk("data", 64'(rd_data), 64'(e[31:0]));
    chk("err", 64'(rd_err), 64'(e[32]));
    chk("last", 64'(rd_last), 64'd1);
    hold = rd_data;
    for (int i = 0; i < stall; i++) begin
      rd_ready = 1'b0;
      tick();
      chk("stall_valid", 64'(rd_valid), 64'd1);
      chk("stall_data", 64'(rd_data), 64'(hold));
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("post_valid", 64'(rd_valid), 64'd0);
    chk("post_busy", 64'(rd_busy), 64'd0);
    chk("en_pulses", 64'(en_pulses - p0), legal ? 64'd1 : 64'd0);
    $display("read addr=%h data=%h err=%0d lat=%0d stall=%0d", a, hold, e[32], n, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    int          s;
    int          off;
    int          n;
    int          p0;
    int          seen;
    logic [DW-1:0] hold;

    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 512; i++) mem[b][i] = $urandom;
    mem[0][7] = 32'h12345678;

    // Reset with a request held: nothing may be accepted
    rst_n   = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 16'h1007;
    repeat (3) tick();
    chk("rst_busy", 64'(rd_busy), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_err", 64'(rd_err), 64'd0);
    chk("rst_last", 64'(rd_last), 64'd0);
    chk("rst_en", 64'(ram_en), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_pulses", 64'(en_pulses), 64'd0);
    rd_req  = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("rst_noacc", 64'(rd_busy), 64'd0);

    // Directed reads: legal bank0 word, then the three illegal forms
    do_read(16'h1007, 0);
    do_read(16'h1020, 1);
    do_read(16'h6000, 0);
    do_read(16'h0000, 2);

    // Long stall with an ignored request in the middle
    p0 = en_pulses;
    rd_req  = 1'b1;
    rd_addr = 16'h50FF;
    tick();
    rd_req = 1'b0;
    n = 0;
    while (!rd_valid && n < 20) begin
      tick();
      n++;
    end
    chk("hold_lat", 64'(n), 64'(1 + LAT));
    chk("hold_data0", 64'(rd_data), 64'(mem[4][255]));
    hold = rd_data;
    for (int i = 0; i < 10; i++) begin
      rd_ready = 1'b0;
      rd_req   = (i == 3);
      rd_addr  = (i == 3) ? 16'h1000 : 16'h50FF;
      tick();
      chk("hold_valid", 64'(rd_valid), 64'd1);
      chk("hold_data", 64'(rd_data), 64'(hold));
    end
    rd_req   = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("hold_post_busy", 64'(rd_busy), 64'd0);
    repeat (2) tick();
    chk("hold_no_second", 64'(rd_busy | rd_valid), 64'd0);
    chk("hold_pulses", 64'(en_pulses - p0), 64'd1);
    $display("read addr=50ff data=%h stall=10 with ignored request", hold);

    // Randomized reads
    for (int t = 0; t < 40; t++) begin
      s = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0 && s >= 1 && s <= NB)
        off = $urandom_range(0, (1 << (BAW + s - 1)) - 1);
      else
        off = $urandom_range(0, 4095);
      a = {4'(s), 12'(off)};
      do_read(a, $urandom_range(0, 3));
    end

`ifdef CORR_RDSEQ_BURST_EN
    // Burst over bank0 with random stalls
    for (int i = 0; i < 32; i++) mem[0][i] = 32'(i);
    burst_req = 1'b1;
    rd_addr   = 16'h1000;
    tick();
    burst_req = 1'b0;
    seen = 0;
    for (int w = 0; w < 32; w++) begin
      n = 0;
      while (!rd_valid && n < 20) begin
        tick();
        n++;
      end
      chk("burst_gap", 64'(n), (w == 0) ? 64'(1 + LAT) : 64'(2 + LAT));
      chk("burst_data", 64'(rd_data), 64'(w));
      chk("burst_err", 64'(rd_err), 64'd0);
      chk("burst_last", 64'(rd_last), 64'(w == 31));
      hold = rd_data;
      seen = $urandom_range(0, 2);
      for (int i = 0; i < seen; i++) begin
        rd_ready = 1'b0;
        tick();
        chk("burst_stall", 64'(rd_data), 64'(hold));
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      $display("burst word=%0d data=%h last=%0d stall=%0d", w, hold, (w == 31), seen);
    end
    chk("burst_done", 64'(rd_busy), 64'd0);

    // Burst to an illegal bank gives a single FILL word
    burst_req = 1'b1;
    rd_addr   = 16'h7000;
    tick();
    burst_req = 1'b0;
    chk("bill_valid", 64'(rd_valid), 64'd1);
    chk("bill_data", 64'(rd_data), 64'(FILLV));
    chk("bill_err", 64'(rd_err), 64'd1);
    chk("bill_last", 64'(rd_last), 64'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("bill_busy", 64'(rd_busy), 64'd0);
    $display("burst addr=7000 illegal data=%h", FILLV);

    // Reset in the middle of a burst discards it
    burst_req = 1'b1;
    rd_addr   = 16'h1000;
    tick();
    burst_req = 1'b0;
    for (int w = 0; w <= 10; w++) begin
      n = 0;
      while (!rd_valid && n < 20) begin
        tick();
        n++;
      end
      if (w < 10) begin
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
      end
    end
    chk("brst_word10", 64'(rd_data), 64'd10);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    rd_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_valid) seen++;
    end
    rd_ready = 1'b0;
    chk("brst_novalid", 64'(seen), 64'd0);
    chk("brst_busy", 64'(rd_busy), 64'd0);
    $display("burst reset at word 10, valid cycles after=%0d", seen);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
